// File: rtl/dct_block_scheduler_pkg.sv
// -----------------------------------------------------------------------------
// dct_sched_pkg
// Shared types and constants for the DCT block scheduler:
//   WORDS_PER_BLK  words in one 8x8 block
//   BLK_W          block width for the default 32-bit word
//   ID_W/req_id_t  requester identifier carried through the tag FIFO
//   sched_state_e  grant state machine encoding
// -----------------------------------------------------------------------------
package dct_sched_pkg;

  localparam int WORDS_PER_BLK  = 64;
  localparam int DATA_WIDTH_DEF = 32;
  localparam int BLK_W          = WORDS_PER_BLK * DATA_WIDTH_DEF;
  localparam int ID_W           = 3;

  typedef logic [ID_W-1:0] req_id_t;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } sched_state_e;

endpackage : dct_sched_pkg

// File: rtl/dct_block_scheduler_tag_fifo.sv
// -----------------------------------------------------------------------------
// dct_tag_fifo
// In-order FIFO of requester IDs, one entry per block inside the DCT core.
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   push, push_id  write one ID (ignored when full)
//   pop            discard the head entry (ignored when empty)
//   head           ID at the read pointer
//   full, empty    occupancy flags
//   count          number of stored entries
// -----------------------------------------------------------------------------
module dct_tag_fifo
  import dct_sched_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  req_id_t                  push_id,
  input  logic                     pop,
  output req_id_t                  head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  req_id_t          mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [CW-1:0]    count_r;
  logic             push_s;
  logic             pop_s;

  // Overflow and underflow are masked so the pointers can never desynchronise.
  assign push_s = push & ~full;
  assign pop_s  = pop & ~empty;

  // Storage, wrap-around pointers and occupancy counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push_s) begin
        mem_r[wr_ptr_r] <= push_id;
        wr_ptr_r        <= wr_ptr_r + AW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  assign head  = mem_r[rd_ptr_r];
  assign full  = (count_r == CW'(DEPTH));
  assign empty = (count_r == CW'(0));
  assign count = count_r;

endmodule : dct_tag_fifo

// File: rtl/dct_block_scheduler.sv
// -----------------------------------------------------------------------------
// dct_block_scheduler
// Round-robin arbiter sharing one 2-D DCT core between NUM_REQ block
// producers. Granted blocks are muxed to the core; the requester ID is queued
// in a tag FIFO so each coefficient block is steered back to its owner.
// Ports:
//   clk, rst_n                        clock, asynchronous active-low reset
//   req_valid/req_ready/req_data      per-requester input blocks
//   dct_in_valid/ready/data           block stream into the core
//   dct_out_valid/ready/data          coefficient stream from the core
//   resp_valid/resp_ready/resp_data   per-requester responses (data broadcast)
//   outstanding                       blocks currently inside the core
//   err_orphan, err_proto             sticky debug flags
// -----------------------------------------------------------------------------
module dct_block_scheduler
  import dct_sched_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REQ    = 3,
  parameter int MAX_OUTST  = 4
) (
  input  logic                                       clk,
  input  logic                                       rst_n,
  input  logic [NUM_REQ-1:0]                         req_valid,
  output logic [NUM_REQ-1:0]                         req_ready,
  input  logic [NUM_REQ*WORDS_PER_BLK*DATA_WIDTH-1:0] req_data,
  output logic                                       dct_in_valid,
  input  logic                                       dct_in_ready,
  output logic [WORDS_PER_BLK*DATA_WIDTH-1:0]        dct_in_data,
  input  logic                                       dct_out_valid,
  output logic                                       dct_out_ready,
  input  logic [WORDS_PER_BLK*DATA_WIDTH-1:0]        dct_out_data,
  output logic [NUM_REQ-1:0]                         resp_valid,
  input  logic [NUM_REQ-1:0]                         resp_ready,
  output logic [WORDS_PER_BLK*DATA_WIDTH-1:0]        resp_data,
  output logic [$clog2(MAX_OUTST):0]                 outstanding,
  output logic                                       err_orphan,
  output logic                                       err_proto
);

  localparam int BLK_BITS = WORDS_PER_BLK * DATA_WIDTH;
  localparam int CAND_W   = ID_W + 1;

  sched_state_e             state_r;
  req_id_t                  sel_r;
  req_id_t                  rr_ptr_r;
  logic                     err_orphan_r;
  logic                     err_proto_r;

  req_id_t                  pick_s;
  logic                     any_valid_s;
  logic [CAND_W-1:0]        cand_s;
  logic                     sel_valid_s;
  logic [NUM_REQ-1:0]       req_ready_s;
  logic [BLK_BITS-1:0]      in_mux_s;
  logic [NUM_REQ-1:0]       resp_valid_s;
  logic                     head_ready_s;
  logic                     push_s;
  logic                     pop_s;
  req_id_t                  head_s;
  logic                     fifo_full_s;
  logic                     fifo_empty_s;

  // Round-robin pick: first valid requester at or after rr_ptr_r, wrapping.
  always_comb begin
    pick_s      = '0;
    any_valid_s = 1'b0;
    cand_s      = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand_s = {1'b0, rr_ptr_r} + CAND_W'(i);
      if (cand_s >= CAND_W'(NUM_REQ)) begin
        cand_s = cand_s - CAND_W'(NUM_REQ);
      end else begin
        cand_s = cand_s;
      end
      for (int j = 0; j < NUM_REQ; j++) begin
        if (!any_valid_s && req_valid[j] && (cand_s == CAND_W'(j))) begin
          any_valid_s = 1'b1;
          pick_s      = req_id_t'(j);
        end else begin
          any_valid_s = any_valid_s;
        end
      end
    end
  end

  // Forward path: mux the granted block and its handshake.
  always_comb begin
    in_mux_s    = '0;
    sel_valid_s = 1'b0;
    req_ready_s = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (sel_r == req_id_t'(j)) begin
        in_mux_s       = req_data[j*BLK_BITS +: BLK_BITS];
        sel_valid_s    = req_valid[j];
        req_ready_s[j] = (state_r == OFFER) && dct_in_ready;
      end else begin
        req_ready_s[j] = 1'b0;
      end
    end
  end

  // Return path: steer the core output to the requester at the FIFO head.
  always_comb begin
    resp_valid_s = '0;
    head_ready_s = 1'b0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (!fifo_empty_s && (head_s == req_id_t'(j))) begin
        resp_valid_s[j] = dct_out_valid;
        head_ready_s    = resp_ready[j];
      end else begin
        resp_valid_s[j] = 1'b0;
      end
    end
  end

  assign push_s = (state_r == OFFER) && dct_in_ready;
  assign pop_s  = !fifo_empty_s && dct_out_valid && head_ready_s;

  // Grant state machine; the grant is frozen for the whole OFFER phase.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      sel_r       <= '0;
      rr_ptr_r    <= '0;
      err_proto_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (any_valid_s && !fifo_full_s) begin
            state_r <= OFFER;
            sel_r   <= pick_s;
          end
        end
        OFFER: begin
          if (!sel_valid_s) begin
            err_proto_r <= 1'b1;
          end
          if (dct_in_ready) begin
            state_r  <= IDLE;
            rr_ptr_r <= (sel_r == req_id_t'(NUM_REQ - 1)) ? '0 : sel_r + req_id_t'(1);
          end
        end
        default: state_r <= IDLE;
      endcase
    end
  end

  // Sticky flag for core output with no owner; such beats are consumed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_orphan_r <= 1'b0;
    end else if (fifo_empty_s && dct_out_valid) begin
      err_orphan_r <= 1'b1;
    end
  end

  dct_tag_fifo #(
    .DEPTH   (MAX_OUTST)
  ) u_tag_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (push_s),
    .push_id (sel_r),
    .pop     (pop_s),
    .head    (head_s),
    .full    (fifo_full_s),
    .empty   (fifo_empty_s),
    .count   (outstanding)
  );

  assign dct_in_valid  = (state_r == OFFER);
  assign dct_in_data   = in_mux_s;
  assign req_ready     = req_ready_s;
  assign resp_valid    = resp_valid_s;
  assign dct_out_ready = fifo_empty_s ? 1'b1 : head_ready_s;
  assign resp_data     = dct_out_data;
  assign err_orphan    = err_orphan_r;
  assign err_proto     = err_proto_r;

endmodule : dct_block_scheduler

// File: tb/tb_dct_block_scheduler.sv
// -----------------------------------------------------------------------------
// tb_dct_block_scheduler
// Directed bench for dct_block_scheduler. The bench plays both the requesters
// and the DCT core; inputs change on the falling edge and outputs are sampled
// 1 time unit later.
// -----------------------------------------------------------------------------
module tb_dct_block_scheduler;
  import dct_sched_pkg::*;

  localparam int DW   = 32;
  localparam int NR   = 3;
  localparam int MO   = 4;
  localparam int BLKB = WORDS_PER_BLK * DW;

  logic                 clk;
  logic                 rst_n;
  logic [NR-1:0]        req_valid;
  logic [NR-1:0]        req_ready;
  logic [NR*BLKB-1:0]   req_data;
  logic                 dct_in_valid;
  logic                 dct_in_ready;
  logic [BLKB-1:0]      dct_in_data;
  logic                 dct_out_valid;
  logic                 dct_out_ready;
  logic [BLKB-1:0]      dct_out_data;
  logic [NR-1:0]        resp_valid;
  logic [NR-1:0]        resp_ready;
  logic [BLKB-1:0]      resp_data;
  logic [$clog2(MO):0]  outstanding;
  logic                 err_orphan;
  logic                 err_proto;

  int n_cmp = 0;
  int n_mis = 0;

  dct_block_scheduler #(
    .DATA_WIDTH (DW),
    .NUM_REQ    (NR),
    .MAX_OUTST  (MO)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_data      (req_data),
    .dct_in_valid  (dct_in_valid),
    .dct_in_ready  (dct_in_ready),
    .dct_in_data   (dct_in_data),
    .dct_out_valid (dct_out_valid),
    .dct_out_ready (dct_out_ready),
    .dct_out_data  (dct_out_data),
    .resp_valid    (resp_valid),
    .resp_ready    (resp_ready),
    .resp_data     (resp_data),
    .outstanding   (outstanding),
    .err_orphan    (err_orphan),
    .err_proto     (err_proto)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Requester 1 carries the all-ones (Q16.16) block; others a tagged pattern.
  function automatic logic [31:0] pat(input int i, input int k);
    if (i == 1) return 32'h0001_0000;
    else        return 32'hA000_0000 | (32'(i) << 16) | 32'(k);
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n         = 1'b0;
    req_valid     = '0;
    dct_in_ready  = 1'b0;
    dct_out_valid = 1'b0;
    dct_out_data  = '0;
    resp_ready    = '0;
    for (int i = 0; i < NR; i++)
      for (int k = 0; k < WORDS_PER_BLK; k++)
        req_data[(i*WORDS_PER_BLK + k)*DW +: DW] = pat(i, k);

    // Reset values
    repeat (2) @(negedge clk);
    #1;
    check_eq("rst_in_valid",  32'(dct_in_valid),  32'd0);
    check_eq("rst_req_ready", 32'(req_ready),     32'd0);
    check_eq("rst_resp_valid",32'(resp_valid),    32'd0);
    check_eq("rst_out_ready", 32'(dct_out_ready), 32'd1);
    check_eq("rst_outst",     32'(outstanding),   32'd0);
    check_eq("rst_orphan",    32'(err_orphan),    32'd0);
    check_eq("rst_proto",     32'(err_proto),     32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Round-robin: all valid, each response returned during the next offer
    @(negedge clk);
    req_valid    = 3'b111;
    dct_in_ready = 1'b1;
    resp_ready   = 3'b111;
    @(negedge clk);
    for (int g = 0; g < 6; g++) begin
      #1;
      check_eq("rr_grant",   32'(req_ready),     32'd1 << (g % 3));
      check_eq("rr_in_data", dct_in_data[31:0],  pat(g % 3, 0));
      if (g > 0) begin
        dct_out_valid      = 1'b1;
        dct_out_data[31:0] = 32'h0008_0000 + 32'(g);
        #1;
        check_eq("rr_route",     32'(resp_valid),  32'd1 << ((g - 1) % 3));
        check_eq("rr_resp_data", resp_data[31:0],  32'h0008_0000 + 32'(g));
      end
      @(negedge clk);
      dct_out_valid = 1'b0;
      #1;
      check_eq("rr_outst", 32'(outstanding), 32'd1);
      if (g == 5) req_valid = 3'b000;
      @(negedge clk);
    end
    dct_out_valid = 1'b1;
    #1;
    check_eq("rr_route_last", 32'(resp_valid), 32'b100);
    @(negedge clk);
    dct_out_valid = 1'b0;
    #1;
    check_eq("rr_drained", 32'(outstanding), 32'd0);

    // Single requester 1, core ready immediately
    req_valid = 3'b010;
    #1;
    check_eq("single_lat0", 32'(dct_in_valid), 32'd0);
    @(negedge clk);
    #1;
    check_eq("single_in_valid", 32'(dct_in_valid), 32'd1);
    check_eq("single_req_ready", 32'(req_ready), 32'b010);
    check_eq("single_w0",  dct_in_data[31:0],      32'h0001_0000);
    check_eq("single_w63", dct_in_data[63*DW +: DW], 32'h0001_0000);
    @(negedge clk);
    req_valid          = 3'b000;
    dct_out_valid      = 1'b1;
    dct_out_data       = '0;
    dct_out_data[31:0] = 32'h0008_0000;
    resp_ready         = 3'b010;
    #1;
    check_eq("single_outst1",   32'(outstanding),   32'd1);
    check_eq("single_rdy_low",  32'(req_ready),     32'd0);
    check_eq("single_resp",     32'(resp_valid),    32'b010);
    check_eq("single_out_rdy",  32'(dct_out_ready), 32'd1);
    check_eq("single_dc",       resp_data[31:0],    32'h0008_0000);
    @(negedge clk);
    dct_out_valid = 1'b0;
    #1;
    check_eq("single_outst0", 32'(outstanding), 32'd0);
    check_eq("single_resp0",  32'(resp_valid),  32'd0);

    // Backpressure: rr_ptr is 2, only requester 0 valid
    dct_in_ready = 1'b0;
    req_valid    = 3'b001;
    @(negedge clk);
    for (int c = 0; c < 5; c++) begin
      #1;
      check_eq("bp_in_valid",  32'(dct_in_valid),   32'd1);
      check_eq("bp_req_ready", 32'(req_ready),      32'd0);
      check_eq("bp_sel",       dct_in_data[31:0],   pat(0, 0));
      @(negedge clk);
    end
    dct_in_ready = 1'b1;
    #1;
    check_eq("bp_accept", 32'(req_ready), 32'b001);
    @(negedge clk);
    req_valid = 3'b000;
    #1;
    check_eq("bp_outst",   32'(outstanding),  32'd1);
    check_eq("bp_idle",    32'(dct_in_valid), 32'd0);

    // FIFO full: responses stalled, grants 1,2,0 fill to 4
    @(negedge clk);
    resp_ready = 3'b000;
    req_valid  = 3'b111;
    repeat (6) @(negedge clk);
    #1;
    check_eq("full_outst", 32'(outstanding), 32'd4);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      #1;
      check_eq("full_no_grant", 32'(dct_in_valid), 32'd0);
    end
    dct_out_valid = 1'b1;
    resp_ready    = 3'b111;
    #1;
    check_eq("full_head0", 32'(resp_valid), 32'b001);
    @(negedge clk);
    dct_out_valid = 1'b0;
    #1;
    check_eq("full_outst3",  32'(outstanding),  32'd3);
    check_eq("full_wait",    32'(dct_in_valid), 32'd0);
    @(negedge clk);
    #1;
    check_eq("full_regrant", 32'(dct_in_valid), 32'd1);
    check_eq("full_sel1",    32'(req_ready),    32'b010);
    @(negedge clk);
    req_valid     = 3'b000;
    dct_out_valid = 1'b1;
    #1;
    check_eq("full_outst4b", 32'(outstanding), 32'd4);
    check_eq("full_head1",   32'(resp_valid),  32'b010);
    @(negedge clk);
    #1;
    check_eq("full_head2",   32'(resp_valid),  32'b100);
    @(negedge clk);
    dct_out_valid = 1'b0;
    #1;
    check_eq("full_outst2", 32'(outstanding), 32'd2);
    check_eq("clean_orphan", 32'(err_orphan), 32'd0);
    check_eq("clean_proto",  32'(err_proto),  32'd0);

    // Reset with 2 blocks outstanding
    @(negedge clk);
    rst_n         = 1'b0;
    req_valid     = 3'b111;
    dct_out_valid = 1'b1;
    #1;
    check_eq("mrst_outst",     32'(outstanding),   32'd0);
    check_eq("mrst_in_valid",  32'(dct_in_valid),  32'd0);
    check_eq("mrst_req_ready", 32'(req_ready),     32'd0);
    check_eq("mrst_resp",      32'(resp_valid),    32'd0);
    check_eq("mrst_out_ready", 32'(dct_out_ready), 32'd1);
    @(negedge clk);
    dct_out_valid = 1'b0;
    req_valid     = 3'b100;
    rst_n         = 1'b1;
    @(negedge clk);
    #1;
    check_eq("mrst_resume",    32'(req_ready),       32'b100);
    check_eq("mrst_data",      dct_in_data[31:0],    pat(2, 0));
    @(negedge clk);
    req_valid     = 3'b000;
    dct_out_valid = 1'b1;
    #1;
    check_eq("mrst_outst1", 32'(outstanding), 32'd1);
    check_eq("mrst_route",  32'(resp_valid),  32'b100);
    @(negedge clk);
    dct_out_valid = 1'b0;
    #1;
    check_eq("mrst_outst0", 32'(outstanding), 32'd0);

    // Orphan output with empty FIFO
    dct_out_valid = 1'b1;
    resp_ready    = 3'b000;
    #1;
    check_eq("orph_out_ready", 32'(dct_out_ready), 32'd1);
    check_eq("orph_resp",      32'(resp_valid),    32'd0);
    @(negedge clk);
    dct_out_valid = 1'b0;
    #1;
    check_eq("orph_flag",  32'(err_orphan), 32'd1);
    check_eq("orph_proto", 32'(err_proto),  32'd0);

    // Granted requester withdraws during OFFER
    dct_in_ready = 1'b0;
    req_valid    = 3'b001;
    @(negedge clk);
    req_valid = 3'b000;
    #1;
    check_eq("proto_offer", 32'(dct_in_valid), 32'd1);
    @(negedge clk);
    #1;
    check_eq("proto_flag",  32'(err_proto),    32'd1);
    check_eq("proto_hold",  32'(dct_in_valid), 32'd1);
    dct_in_ready = 1'b1;
    @(negedge clk);
    #1;
    check_eq("proto_accept", 32'(outstanding),  32'd1);
    check_eq("proto_idle",   32'(dct_in_valid), 32'd0);
    check_eq("orph_sticky",  32'(err_orphan),   32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule : tb_dct_block_scheduler
